// File: rtl/csr_counter_bank_if.sv
// CSR access bus for csr_counter_bank: one access strobe per cycle,
// registered read data returned with a one-cycle valid pulse.
interface csr_counter_bank_if;
  logic        en_rw;
  logic [4:0]  sel;
  logic        hi;
  logic [1:0]  rw_mode;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output en_rw, sel, hi, rw_mode, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  en_rw, sel, hi, rw_mode, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/csr_counter_bank.sv
// Bank of NCNT free-running CW-bit event counters with 32-bit CSR access
// (read / CSRRW / CSRRS / CSRRC). Define CSR_CNT_INHIBIT_EN to honour inhibit.
module csr_counter_bank #(
  parameter int unsigned NCNT = 3,
  parameter int unsigned CW   = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NCNT-1:0] inc,
  input  logic [NCNT-1:0] inhibit,
  output logic [NCNT-1:0] ovf,
  csr_counter_bank_if.slave bus
);

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } op_e;

  logic [CW-1:0]   cnt_q [NCNT];
  logic [CW-1:0]   cnt_d [NCNT];
  logic [NCNT-1:0] ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic [NCNT-1:0] cnt_en;
  op_e             op;
  logic            in_range;
  logic [63:0]     sel_ext;
  logic [63:0]     wr_ext;
  logic [31:0]     half_old;
  logic [31:0]     half_new;
  logic            wr_en;

`ifdef CSR_CNT_INHIBIT_EN
  assign cnt_en = inc & ~inhibit;
`else
  logic unused_inhibit;
  assign unused_inhibit = ^inhibit;
  assign cnt_en         = inc;
`endif

  assign op = op_e'(bus.rw_mode);

  // Counters are viewed through a 64-bit zero-extended window so the high
  // half reads zero-extended and writes beyond CW bits simply fall away.
  always_comb begin
    in_range = 1'b0;
    sel_ext  = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (bus.sel == 5'(i)) begin
        in_range = 1'b1;
        sel_ext  = 64'(cnt_q[i]);
      end
    end

    half_old = bus.hi ? sel_ext[63:32] : sel_ext[31:0];

    half_new = half_old;
    unique case (op)
      OP_RW:   half_new = bus.wdata;
      OP_RS:   half_new = half_old | bus.wdata;
      OP_RC:   half_new = half_old & ~bus.wdata;
      default: half_new = half_old;
    endcase

    // Set/clear with a zero operand is a pure read and must not block counting.
    wr_en = bus.en_rw && in_range
         && ((op == OP_RW) || ((op != OP_READ) && (bus.wdata != '0)))
         && !(bus.hi && (CW == 32));
  end

  always_comb begin
    rvalid_d = bus.en_rw;
    rdata_d  = rdata_q;
    if (bus.en_rw) begin
      rdata_d = in_range ? half_old : '0;
    end

    wr_ext = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = 1'b0;
      if (wr_en && (bus.sel == 5'(i))) begin
        wr_ext = 64'(cnt_q[i]);
        if (bus.hi) begin
          wr_ext[63:32] = half_new;
        end else begin
          wr_ext[31:0] = half_new;
        end
        cnt_d[i] = wr_ext[CW-1:0];
      end else if (cnt_en[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
        ovf_d[i] = &cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ovf        = ovf_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank: expected read data and ovf are queued
// when each cycle is driven and compared on the following falling edge.
module tb_csr_counter_bank;
  localparam int unsigned NCNT = 3;
  localparam int unsigned CW   = 64;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

`ifdef CSR_CNT_INHIBIT_EN
  localparam logic [31:0] INH_EXP = 32'h0;
`else
  localparam logic [31:0] INH_EXP = 32'd10;
`endif

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [NCNT-1:0] inc = '0;
  logic [NCNT-1:0] inhibit = '0;
  logic [NCNT-1:0] ovf;

  csr_counter_bank_if bus ();

  csr_counter_bank #(.NCNT(NCNT), .CW(CW)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .inc     (inc),
    .inhibit (inhibit),
    .ovf     (ovf),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rvalid;
    logic [31:0]     rdata;
    logic [NCNT-1:0] ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 1'b0;
  logic [63:0] m_cnt [NCNT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rvalid", 64'(bus.rvalid), 64'(e.rvalid));
          if (e.rvalid) check("rdata", 64'(bus.rdata), 64'(e.rdata));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end else begin
          check("idle_rvalid", 64'(bus.rvalid), 64'h0);
          check("idle_ovf", 64'(ovf), 64'h0);
        end
      end
    end
  end

  // One driven cycle: apply inputs, advance the reference model, queue expectations.
  task automatic step(input logic [NCNT-1:0] inc_v, input logic [NCNT-1:0] inh_v,
                      input logic en, input int s, input logic h, input logic [1:0] m,
                      input logic [31:0] wd, input bit use_k = 1'b0,
                      input logic [31:0] k = 32'h0);
    exp_t            e;
    logic [63:0]     v;
    logic [31:0]     half;
    bit              wr;
    logic [NCNT-1:0] act;
    @(negedge clk);
    inc         = inc_v;
    inhibit     = inh_v;
    bus.en_rw   = en;
    bus.sel     = 5'(s);
    bus.hi      = h;
    bus.rw_mode = m;
    bus.wdata   = wd;
    e.rvalid = en;
    e.rdata  = '0;
    e.ovf    = '0;
    half     = '0;
    if (s < NCNT) begin
      v    = m_cnt[s];
      half = h ? v[63:32] : v[31:0];
      if (en) e.rdata = half;
    end
    if (use_k) e.rdata = k;
    wr = en && (s < NCNT) && ((m == RW) || ((m != RD) && (wd != 32'h0)));
`ifdef CSR_CNT_INHIBIT_EN
    act = inc_v & ~inh_v;
`else
    act = inc_v;
`endif
    for (int i = 0; i < NCNT; i++) begin
      if (wr && (s == i)) begin
        case (m)
          RW:      half = wd;
          RS:      half = half | wd;
          RC:      half = half & ~wd;
          default: half = half;
        endcase
        if (h) m_cnt[i][63:32] = half;
        else   m_cnt[i][31:0]  = half;
      end else if (act[i]) begin
        if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
          m_cnt[i]   = 64'h0;
          e.ovf[i]   = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 64'h1;
        end
      end
    end
    @(posedge clk);
    sb.push_back(e);
  endtask

  task automatic rd(input int c, input logic h, input logic [31:0] k);
    step('0, '0, 1'b1, c, h, RD, 32'h0, 1'b1, k);
  endtask

  task automatic wr(input int c, input logic h, input logic [31:0] v);
    step('0, '0, 1'b1, c, h, RW, v);
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 0, 1'b0, RD, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCNT-1:0] r_inc, r_inh;
    logic [31:0]     r_wd;
    bus.en_rw   = 1'b1;
    bus.sel     = '0;
    bus.hi      = 1'b0;
    bus.rw_mode = RW;
    bus.wdata   = 32'hFFFF_FFFF;
    inc         = '1;
    for (int i = 0; i < NCNT; i++) m_cnt[i] = 64'h0;

    // Held in reset with activity on the inputs; nothing may register.
    #12;
    check("rst_rdata", 64'(bus.rdata), 64'h0);
    check("rst_rvalid", 64'(bus.rvalid), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);

    @(negedge clk);
    bus.en_rw = 1'b0;
    inc       = 3'b001;
    nreset    = 1'b1;
    m_cnt[0]  = 64'h1;
    #1 mon_en = 1'b1;

    // First edge after release counts.
    rd(0, 1'b0, 32'h1);

    // Low-to-high carry with no skew.
    wr(0, 1'b0, 32'hFFFF_FFFF);
    wr(0, 1'b1, 32'h0);
    step(3'b001, '0, 1'b0, 0, 1'b0, RD, 32'h0);
    rd(0, 1'b1, 32'h1);
    rd(0, 1'b0, 32'h0);

    // Full wrap with one-cycle ovf pulse.
    wr(1, 1'b0, 32'hFFFF_FFFF);
    wr(1, 1'b1, 32'hFFFF_FFFF);
    step(3'b010, '0, 1'b0, 0, 1'b0, RD, 32'h0);
    rd(1, 1'b0, 32'h0);
    rd(1, 1'b1, 32'h0);

    // Write beats a same-cycle increment and returns the old value.
    wr(2, 1'b0, 32'hAAAA_0001);
    wr(2, 1'b1, 32'h0);
    step(3'b100, '0, 1'b1, 2, 1'b0, RW, 32'h1234_5678, 1'b1, 32'hAAAA_0001);
    rd(2, 1'b0, 32'h1234_5678);
    rd(2, 1'b1, 32'h0);

    // Set / clear and the zero-operand read case.
    wr(0, 1'b0, 32'h0F0);
    wr(0, 1'b1, 32'h0);
    step('0, '0, 1'b1, 0, 1'b0, RS, 32'h00F, 1'b1, 32'h0F0);
    rd(0, 1'b0, 32'h0FF);
    step('0, '0, 1'b1, 0, 1'b0, RC, 32'h0F0, 1'b1, 32'h0FF);
    rd(0, 1'b0, 32'h00F);
    step(3'b001, '0, 1'b1, 0, 1'b0, RS, 32'h0, 1'b1, 32'h00F);
    rd(0, 1'b0, 32'h010);

    // Out-of-range selects read zero and write nothing.
    step('0, '0, 1'b1, 5, 1'b0, RW, 32'hDEAD_BEEF, 1'b1, 32'h0);
    step('0, '0, 1'b1, 31, 1'b1, RS, 32'hFFFF_FFFF, 1'b1, 32'h0);
    rd(0, 1'b0, 32'h010);

    // A write to one counter leaves the others counting.
    step(3'b111, '0, 1'b1, 0, 1'b0, RW, 32'h100);
    rd(0, 1'b0, 32'h100);
    rd(1, 1'b0, 32'h1);
    rd(2, 1'b0, 32'h1234_5679);

    // Inhibit on counter 0 only.
    wr(0, 1'b0, 32'h0);
    repeat (10) step(3'b001, 3'b001, 1'b0, 0, 1'b0, RD, 32'h0);
    rd(0, 1'b0, INH_EXP);

    // Randomised traffic against the reference model.
    repeat (300) begin
      r_inc = NCNT'($urandom);
      r_inh = NCNT'($urandom);
      case ($urandom_range(0, 3))
        0:       r_wd = 32'h0;
        1:       r_wd = 32'hFFFF_FFFF;
        default: r_wd = $urandom;
      endcase
      step(r_inc, r_inh, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r_wd);
    end

    // Asynchronous reset mid-count.
    wr(0, 1'b0, 32'h55);
    wr(0, 1'b1, 32'h0);
    idle();
    @(negedge clk);
    #1 mon_en = 1'b0;
    bus.en_rw   = 1'b1;
    bus.sel     = 5'd0;
    bus.hi      = 1'b0;
    bus.rw_mode = RD;
    inc         = 3'b111;
    @(posedge clk);
    #1;
    check("pre_rst_rvalid", 64'(bus.rvalid), 64'h1);
    check("pre_rst_rdata", 64'(bus.rdata), 64'h55);
    #1 nreset = 1'b0;
    #1;
    check("async_rdata", 64'(bus.rdata), 64'h0);
    check("async_rvalid", 64'(bus.rvalid), 64'h0);
    check("async_ovf", 64'(ovf), 64'h0);
    bus.rw_mode = RW;
    bus.wdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < NCNT; i++) m_cnt[i] = 64'h0;
    @(negedge clk);
    @(negedge clk);
    bus.en_rw = 1'b0;
    inc       = '0;
    nreset    = 1'b1;
    #1 mon_en = 1'b1;
    rd(0, 1'b0, 32'h0);
    rd(1, 1'b1, 32'h0);
    idle();

    repeat (20) if (sb.size() > 0) @(negedge clk);
    check("drain", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_counter_bank.md
CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 Parameter NCNT, default 3: number of independent counters (1..32).
REQ-002 Parameter CW, default 64: counter width (32..64); bits [31:0] form the low half, bits [CW-1:32] the high half.
REQ-003 Port clk, input, 1: clock; all state changes on rising edge.
REQ-004 Port nreset, input, 1: reset, asynchronous, active-low.
REQ-005 Port inc, input, NCNT: per-counter increment event, sampled each cycle.
REQ-006 Port inhibit, input, NCNT: per-counter count-inhibit, mcountinhibit style.
REQ-007 Port en_rw, input, 1: CSR access strobe, one access per asserted cycle.
REQ-008 Port sel, input, 5: counter index for the access.
REQ-009 Port hi, input, 1: 0 selects the low half, 1 selects the high half.
REQ-010 Port rw_mode, input, 2: 00 read, 01 CSRRW, 10 CSRRS, 11 CSRRC.
REQ-011 Port wdata, input, 32: write/set/clear operand.
REQ-012 Port rdata, output, 32: registered read data.
REQ-013 Port rvalid, output, 1: rdata valid, one-cycle pulse.
REQ-014 Port ovf, output, NCNT: per-counter wrap pulse.

Function
REQ-015 Counter n SHALL increment by 1 in a cycle when inc[n]=1, it is not inhibited, and it is not written that cycle.
REQ-016 Increment SHALL be full CW-bit: low-half carry propagates into the high half in the same cycle, with no one-cycle skew.
REQ-017 When all-ones increments, the counter SHALL wrap to 0 and ovf[n] SHALL pulse high for exactly the next cycle.
REQ-018 An access with en_rw=1 SHALL register rdata = the selected half's value before that cycle's update, with rvalid=1 on the following cycle (1-cycle latency).
REQ-019 The high half SHALL read zero-extended from CW-32 bits; with CW=32 it SHALL read 0 and ignore writes.
REQ-020 CSRRW SHALL load wdata into the selected half; CSRRS SHALL OR it in; CSRRC SHALL AND it with ~wdata; the other half is unchanged.
REQ-021 CSRRS or CSRRC with wdata=0 SHALL be treated as a read: no write, and the counter still increments.
REQ-022 A write to counter n SHALL take priority over inc[n] in the same cycle: the increment is lost, no carry occurs, and no ovf pulse is produced.
REQ-023 A write to one counter SHALL NOT affect increments of other counters in the same cycle.
REQ-024 sel >= NCNT SHALL return rdata=0 with rvalid=1, and any write SHALL be ignored.
REQ-025 rvalid and ovf SHALL be 0 in every cycle not defined above.

Reset
REQ-026 Asserting nreset SHALL immediately clear all counters, rdata, rvalid and ovf to 0, independent of clk.
REQ-027 An access or increment coinciding with reset assertion SHALL be discarded.
REQ-028 The first increment SHALL occur on the first rising edge after nreset deasserts with inc=1.

Configuration
REQ-029 Macro CSR_CNT_INHIBIT_EN defined: inhibit[n]=1 SHALL block increments of counter n, while CSR reads and writes are unaffected.
REQ-030 Macro CSR_CNT_INHIBIT_EN undefined: the inhibit port SHALL remain present but be ignored, and all counters count freely.

Verification
REQ-031 Counter 0 at 0x0000_0000_FFFF_FFFF with inc[0]=1 for one cycle -> reads 0x0000_0001 at hi=1 and 0x0000_0000 at hi=0.
REQ-032 Counter 1 at all-ones with inc[1]=1 -> counter reads 0, and ovf[1]=1 for exactly one cycle.
REQ-033 CSRRW of 0x1234_5678 to counter 2 low half with inc[2]=1 in the same cycle -> rvalid next cycle with rdata = old value, then a later read returns 0x1234_5678.
REQ-034 Counter at 0x0F0 low half: CSRRS 0x00F -> 0x0FF; CSRRC 0x0F0 -> 0x00F; CSRRS with wdata=0 and inc=1 -> 0x010.
REQ-035 With the macro defined and inhibit[0]=1, 10 cycles of inc[0]=1 -> count unchanged; without the macro -> count +10.
REQ-036 nreset pulsed low mid-count at 0x55 -> all outputs 0 asynchronously, and a read after release returns 0.
